multi_phase_signal_ctrl: RTL
============================

MULTI_PHASE_SIGNAL_CTRL -- requirements
Module: multi_phase_signal_ctrl

Interface
REQ-001 Parameter NUM_PHASES, default 3: number of signal phases (approaches), legal 2..8.
REQ-002 Parameter TIME_W, default 4: width of each timing parameter, in ticks.
REQ-003 Parameter TICK_DIV, default 4: clock cycles per timing tick, legal >= 2.
REQ-004 globalClk  in  1  single clock, all state updates on its rising edge.
REQ-005 resetIn  in  1  asynchronous, active-high reset.
REQ-006 sensorIn  in  NUM_PHASES  per-phase vehicle demand, asynchronous level.
REQ-007 walkRqstIn  in  1  pedestrian request, asynchronous level.
REQ-008 reprogramIn  in  1  parameter-write strobe, asynchronous level.
REQ-009 timeValIn  in  TIME_W  value written on reprogram.
REQ-010 timeParamSel  in  2  write target: 0 base green, 1 extended green, 2 yellow, 3 walk.
REQ-011 greenOut, yellowOut, redOut  out  NUM_PHASES each  per-phase lamps, registered.
REQ-012 walkOut  out  1  pedestrian walk lamp, registered.
REQ-013 phaseOut  out  clog2(NUM_PHASES)  index of the active phase, registered.

Function
REQ-014 sensorIn, walkRqstIn and reprogramIn SHALL each pass through a 2-flop synchronizer; all latencies below count from the synchronized signal.
REQ-015 A tick counter SHALL count 0..TICK_DIV-1 and SHALL clear on every state entry, so a state loaded with N lasts exactly N*TICK_DIV cycles.
REQ-016 A stored parameter of 0 SHALL be treated as 1 tick.
REQ-017 States: GREEN_BASE, GREEN_EXT, YELLOW, WALK.
REQ-018 In GREEN_BASE and GREEN_EXT: greenOut[p]=1; all other phases red.
REQ-019 In YELLOW: yellowOut[p]=1; all other phases red.
REQ-020 In WALK: all phases red and walkOut=1.
REQ-021 Exactly one of green/yellow/red SHALL be high per phase in every cycle.
REQ-022 GREEN_BASE expiry: if synchronized sensorIn[p]=1 in the expiry cycle, go to GREEN_EXT (extended-green time); otherwise go to YELLOW.
REQ-023 GREEN_EXT expiry SHALL go to YELLOW; an extension occurs at most once per green.
REQ-024 YELLOW expiry: if the walk latch is set, go to WALK; otherwise go to GREEN_BASE of the next phase.
REQ-025 WALK expiry SHALL go to GREEN_BASE of the next phase.
REQ-026 Per-phase demand latch SHALL set while synchronized sensorIn[i]=1.
REQ-027 Demand latch i SHALL clear on entry to GREEN_BASE of phase i; if set and clear coincide, set SHALL win.
REQ-028 Next phase SHALL be the lowest index above p, with wrap-around, whose demand latch is set; if none is set, the next phase SHALL be phase 0, including from phase 0 itself.
REQ-029 Walk latch SHALL set while synchronized walkRqstIn=1 and SHALL clear on WALK entry; if set and clear coincide, set SHALL win.
REQ-030 A rising edge of synchronized reprogramIn SHALL write timeValIn into the register selected by timeParamSel.
REQ-031 The same reprogram edge SHALL force GREEN_BASE of phase 0 on the next cycle, restarting the timer.
REQ-032 Demand and walk latches SHALL be preserved across a reprogram.
REQ-033 A reprogram edge coinciding with a state expiry SHALL take priority over the expiry transition.
REQ-034 A new parameter value SHALL take effect at the next state entry that uses it.

Reset
REQ-035 While resetIn=1, and immediately when it asserts: state GREEN_BASE, phase 0, greenOut=1 on bit 0, redOut set on all other bits, yellowOut=0, walkOut=0, phaseOut=0.
REQ-036 Reset SHALL also clear all latches, synchronizers and counters, and load parameters base=6, ext=3, yellow=2, walk=3.
REQ-037 After resetIn deasserts, the first GREEN_BASE SHALL last a full base time.

Verification (NUM_PHASES=3, TICK_DIV=4)
REQ-038 Reset, no inputs -> greenOut=001 for 24 cycles, then yellowOut=001 for 8 cycles, then greenOut=001 again, repeating.
REQ-039 sensorIn[2] pulsed 3 cycles during phase-0 green -> after phase-0 yellow, greenOut=100 and phaseOut=2, phase 1 skipped; then return to phase 0.
REQ-040 sensorIn[0] held high -> phase-0 green lasts 36 cycles (base 24 + ext 12) before yellow.
REQ-041 walkRqstIn pulsed during green -> after yellow, redOut=111 and walkOut=1 for 12 cycles, then next-phase green.
REQ-042 Reprogram sel=2, val=0, issued mid-green -> green restarts on phase 0 within 4 cycles of the edge; subsequent yellow lasts 4 cycles.
REQ-043 resetIn asserted mid-yellow on phase 1 -> same cycle greenOut=001, walkOut=0, latches cleared.

Source files
------------

// File: rtl/multi_phase_signal_ctrl.sv
// -----------------------------------------------------------------------------
// multi_phase_signal_ctrl
//
// Traffic signal controller that serves NUM_PHASES approaches one at a time.
// Each served phase runs GREEN_BASE, an optional single GREEN_EXT when its
// sensor is still active at base expiry, then YELLOW. An optional WALK
// interval (all red) follows the yellow when a pedestrian request is
// pending. The next phase is chosen from per-phase demand latches. Timing
// parameters are run-time programmable through a strobe/select/value port.
//
// Ports
//   globalClk     in   1           clock, all state changes on the rising edge
//   resetIn       in   1           asynchronous active-high reset
//   sensorIn      in   NUM_PHASES  per-phase vehicle demand (asynchronous level)
//   walkRqstIn    in   1           pedestrian request (asynchronous level)
//   reprogramIn   in   1           parameter write strobe (asynchronous level)
//   timeValIn     in   TIME_W      value written on a reprogram rising edge
//   timeParamSel  in   2           0 base green, 1 extended green, 2 yellow, 3 walk
//   greenOut      out  NUM_PHASES  per-phase green lamps (registered)
//   yellowOut     out  NUM_PHASES  per-phase yellow lamps (registered)
//   redOut        out  NUM_PHASES  per-phase red lamps (registered)
//   walkOut       out  1           pedestrian walk lamp (registered)
//   phaseOut      out  PH_W        index of the active phase (registered)
//   state_dbg     out  2           current FSM state, for observation only
//
// Handshake: there is no valid/ready traffic on this block. The three
// asynchronous inputs are level signals sampled through 2-flop
// synchronizers; a reprogram acts on the rising edge of its synchronized
// copy, with timeValIn/timeParamSel expected to be stable around that edge.
// -----------------------------------------------------------------------------
module multi_phase_signal_ctrl #(
  parameter int NUM_PHASES = 3,
  parameter int TIME_W     = 4,
  parameter int TICK_DIV   = 4,
  localparam int PH_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic                  globalClk,
  input  logic                  resetIn,
  input  logic [NUM_PHASES-1:0] sensorIn,
  input  logic                  walkRqstIn,
  input  logic                  reprogramIn,
  input  logic [TIME_W-1:0]     timeValIn,
  input  logic [1:0]            timeParamSel,
  output logic [NUM_PHASES-1:0] greenOut,
  output logic [NUM_PHASES-1:0] yellowOut,
  output logic [NUM_PHASES-1:0] redOut,
  output logic                  walkOut,
  output logic [PH_W-1:0]       phaseOut,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] ST_GREEN_BASE = 2'd0;
  localparam logic [1:0] ST_GREEN_EXT  = 2'd1;
  localparam logic [1:0] ST_YELLOW     = 2'd2;
  localparam logic [1:0] ST_WALK       = 2'd3;

  localparam logic [TIME_W-1:0] RST_BASE  = TIME_W'(6);
  localparam logic [TIME_W-1:0] RST_EXT   = TIME_W'(3);
  localparam logic [TIME_W-1:0] RST_YEL   = TIME_W'(2);
  localparam logic [TIME_W-1:0] RST_WALK  = TIME_W'(3);

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic [NUM_PHASES-1:0] sens_s1, sens_s2;
  logic                  walk_s1, walk_s2;
  logic                  rp_s1, rp_s2, rp_s3;
  logic                  rp_edge;

  always_ff @(posedge globalClk or posedge resetIn) begin
    if (resetIn) begin
      sens_s1 <= '0;
      sens_s2 <= '0;
      walk_s1 <= 1'b0;
      walk_s2 <= 1'b0;
      rp_s1   <= 1'b0;
      rp_s2   <= 1'b0;
      rp_s3   <= 1'b0;
    end else begin
      sens_s1 <= sensorIn;
      sens_s2 <= sens_s1;
      walk_s1 <= walkRqstIn;
      walk_s2 <= walk_s1;
      rp_s1   <= reprogramIn;
      rp_s2   <= rp_s1;
      rp_s3   <= rp_s2;
    end
  end

  // rp_s3 is only the previous value of the synchronized strobe, used to
  // find its rising edge.
  assign rp_edge = rp_s2 & ~rp_s3;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [TIME_W-1:0]     base_r, ext_r, yel_r, walk_time_r;
  logic [TIME_W-1:0]     base_d, ext_d, yel_d, walk_time_d;
  logic [1:0]            state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [CNT_W-1:0]      tick_q, tick_d;
  logic [TIME_W-1:0]     remain_q, remain_d;
  logic [NUM_PHASES-1:0] demand_q, demand_d;
  logic                  walk_latch_q, walk_latch_d;

  logic                  enter;
  logic [TIME_W-1:0]     load_val;
  logic [NUM_PHASES-1:0] clear_mask;
  logic                  tick_last;
  logic                  expire;
  logic [PH_W-1:0]       next_phase;

  logic [NUM_PHASES-1:0] green_d, yellow_d, red_d;
  logic                  walk_lamp_d;

  // A stored zero still gives the state one full tick.
  function automatic logic [TIME_W-1:0] eff_ticks(input logic [TIME_W-1:0] v);
    return (v == '0) ? TIME_W'(1) : v;
  endfunction

  // Search upward from the current phase with wrap-around. The current phase
  // itself is the last candidate; with no demand anywhere the answer is 0.
  function automatic logic [PH_W-1:0] pick_next(
    input logic [PH_W-1:0]       cur,
    input logic [NUM_PHASES-1:0] dem
  );
    logic [PH_W-1:0] nxt;
    logic            found;
    int              idx;
    nxt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      idx = (int'(cur) + k) % NUM_PHASES;
      if (!found && dem[idx]) begin
        nxt   = PH_W'(idx);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  assign tick_last  = (tick_q == CNT_W'(TICK_DIV - 1));
  // remain_q counts whole ticks left including the current one, so the last
  // cycle of the last tick is the expiry cycle.
  assign expire     = tick_last && (remain_q == TIME_W'(1));
  assign next_phase = pick_next(phase_q, demand_q);

  // Parameter write. Loads below use the post-write values so a write that
  // coincides with a state entry is already visible to that entry.
  always_comb begin
    base_d      = base_r;
    ext_d       = ext_r;
    yel_d       = yel_r;
    walk_time_d = walk_time_r;
    if (rp_edge) begin
      case (timeParamSel)
        2'd0:    base_d      = timeValIn;
        2'd1:    ext_d       = timeValIn;
        2'd2:    yel_d       = timeValIn;
        default: walk_time_d = timeValIn;
      endcase
    end
  end

  // Next-state logic. A reprogram edge outranks any expiry in the same cycle.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    enter      = 1'b0;
    load_val   = remain_q;
    clear_mask = '0;
    if (rp_edge) begin
      // Restart on phase 0 without touching the demand latches.
      state_d  = ST_GREEN_BASE;
      phase_d  = '0;
      enter    = 1'b1;
      load_val = eff_ticks(base_d);
    end else if (expire) begin
      enter = 1'b1;
      case (state_q)
        ST_GREEN_BASE: begin
          if (sens_s2[phase_q]) begin
            state_d  = ST_GREEN_EXT;
            load_val = eff_ticks(ext_d);
          end else begin
            state_d  = ST_YELLOW;
            load_val = eff_ticks(yel_d);
          end
        end
        ST_GREEN_EXT: begin
          // Extension never repeats: an extended green always goes to yellow.
          state_d  = ST_YELLOW;
          load_val = eff_ticks(yel_d);
        end
        ST_YELLOW: begin
          if (walk_latch_q) begin
            state_d  = ST_WALK;
            load_val = eff_ticks(walk_time_d);
          end else begin
            state_d             = ST_GREEN_BASE;
            phase_d             = next_phase;
            load_val            = eff_ticks(base_d);
            clear_mask[next_phase] = 1'b1;
          end
        end
        default: begin
          // WALK keeps phaseOut at the phase just served until it ends.
          state_d             = ST_GREEN_BASE;
          phase_d             = next_phase;
          load_val            = eff_ticks(base_d);
          clear_mask[next_phase] = 1'b1;
        end
      endcase
    end
  end

  // Tick timer: cleared on every entry so a state of N ticks lasts exactly
  // N*TICK_DIV cycles.
  always_comb begin
    tick_d   = tick_q;
    remain_d = remain_q;
    if (enter) begin
      tick_d   = '0;
      remain_d = load_val;
    end else if (tick_last) begin
      tick_d   = '0;
      remain_d = remain_q - TIME_W'(1);
    end else begin
      tick_d   = tick_q + CNT_W'(1);
    end
  end

  // Latches: setting has priority over clearing in the same cycle.
  always_comb begin
    demand_d     = (demand_q & ~clear_mask) | sens_s2;
    walk_latch_d = (walk_latch_q & ~(enter && (state_d == ST_WALK))) | walk_s2;
  end

  // Lamp decode from the next state so the lamp registers line up with the
  // state registers.
  always_comb begin
    green_d     = '0;
    yellow_d    = '0;
    red_d       = '1;
    walk_lamp_d = 1'b0;
    case (state_d)
      ST_GREEN_BASE, ST_GREEN_EXT: begin
        green_d[phase_d] = 1'b1;
        red_d[phase_d]   = 1'b0;
      end
      ST_YELLOW: begin
        yellow_d[phase_d] = 1'b1;
        red_d[phase_d]    = 1'b0;
      end
      default: walk_lamp_d = 1'b1;
    endcase
  end

  always_ff @(posedge globalClk or posedge resetIn) begin
    if (resetIn) begin
      base_r       <= RST_BASE;
      ext_r        <= RST_EXT;
      yel_r        <= RST_YEL;
      walk_time_r  <= RST_WALK;
      state_q      <= ST_GREEN_BASE;
      phase_q      <= '0;
      tick_q       <= '0;
      remain_q     <= RST_BASE;
      demand_q     <= '0;
      walk_latch_q <= 1'b0;
      greenOut     <= NUM_PHASES'(1);
      yellowOut    <= '0;
      redOut       <= ~NUM_PHASES'(1);
      walkOut      <= 1'b0;
      phaseOut     <= '0;
    end else begin
      base_r       <= base_d;
      ext_r        <= ext_d;
      yel_r        <= yel_d;
      walk_time_r  <= walk_time_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      tick_q       <= tick_d;
      remain_q     <= remain_d;
      demand_q     <= demand_d;
      walk_latch_q <= walk_latch_d;
      greenOut     <= green_d;
      yellowOut    <= yellow_d;
      redOut       <= red_d;
      walkOut      <= walk_lamp_d;
      phaseOut     <= phase_d;
    end
  end

  assign state_dbg = state_q;

endmodule
